// File: rtl/maxpool1_relu_layer.sv
// ---------------------------------------------------------------------------
// maxpool1_relu_layer
//
// Downstream stage of the first convolution layer. Takes the 3-channel conv1
// raster stream, applies ReLU, then 2x2 / stride-2 max pooling, and emits a
// 3-channel (IN_WIDTH/2) x (IN_HEIGHT/2) stream. There is no backpressure:
// every valid_in beat is accepted.
//
// Build option:
//   MAXPOOL1_RELU_EN  defined   -> ReLU clamps negative samples to 0 before
//                                  pooling (all outputs >= 0).
//                     undefined -> pooling runs on raw signed samples.
//
// Ports:
//   clk                  clock, single domain
//   rst                  synchronous, active-high reset
//   data_in_1..3         per-channel signed conv samples (DATA_W bits)
//   valid_in             one sample beat for all 3 channels, raster order
//   pool_out_1..3        per-channel pooled result, held between pulses
//   valid_out            1-cycle pulse per pooled pixel
//   frame_done           1-cycle pulse together with the last valid_out
//   busy                 high from the first beat of a frame to frame_done
// ---------------------------------------------------------------------------
module maxpool1_relu_layer #(
  parameter int IN_WIDTH  = 24,
  parameter int IN_HEIGHT = 24,
  parameter int DATA_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic              valid_in,
  output logic [DATA_W-1:0] pool_out_1,
  output logic [DATA_W-1:0] pool_out_2,
  output logic [DATA_W-1:0] pool_out_3,
  output logic              valid_out,
  output logic              frame_done,
  output logic              busy
);

  localparam int HALF_W = IN_WIDTH / 2;
  localparam int CW     = (IN_WIDTH  > 2) ? $clog2(IN_WIDTH)  : 1;
  localparam int RW     = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
  localparam int LB_AW  = (HALF_W    > 1) ? $clog2(HALF_W)    : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVEN = 2'd1,
    S_ODD  = 2'd2
  } state_t;

  // ReLU, compiled away when the feature is not built in.
  function automatic logic signed [DATA_W-1:0] relu_f(input logic signed [DATA_W-1:0] v);
`ifdef MAXPOOL1_RELU_EN
    relu_f = v[DATA_W-1] ? {DATA_W{1'b0}} : v;
`else
    relu_f = v;
`endif
  endfunction

  // Signed maximum; on a tie either operand is the same value.
  function automatic logic signed [DATA_W-1:0] max_f(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    max_f = (a > b) ? a : b;
  endfunction

  state_t                    state_r;
  logic [CW-1:0]             col_r;
  logic [RW-1:0]             row_r;
  logic signed [DATA_W-1:0]  pair_r     [3];
  logic signed [DATA_W-1:0]  line_buf_r [3][HALF_W];
  logic signed [DATA_W-1:0]  pool_r     [3];
  logic                      valid_out_r;
  logic                      frame_done_r;
  logic                      busy_r;

  logic signed [DATA_W-1:0]  x_s    [3];
  logic signed [DATA_W-1:0]  m_s    [3];
  logic signed [DATA_W-1:0]  pool_s [3];
  logic [LB_AW-1:0]          lb_idx_s;
  logic                      col_odd_s;
  logic                      col_wrap_s;
  logic                      row_last_s;
  logic                      row_odd_s;

  // Position decode and per-channel ReLU / horizontal / vertical max.
  // Counters sit at 0 whenever the FSM is idle, so an IDLE beat decodes
  // naturally as pixel (0,0) of an even row.
  always_comb begin
    col_odd_s  = col_r[0];
    col_wrap_s = (col_r == CW'(IN_WIDTH - 1));
    row_last_s = (row_r == RW'(IN_HEIGHT - 1));
    row_odd_s  = (state_r == S_ODD);
    lb_idx_s   = LB_AW'(col_r >> 1);
    x_s[0]     = relu_f(data_in_1);
    x_s[1]     = relu_f(data_in_2);
    x_s[2]     = relu_f(data_in_3);
    for (int ch = 0; ch < 3; ch++) begin
      m_s[ch]    = max_f(pair_r[ch], x_s[ch]);
      pool_s[ch] = max_f(line_buf_r[ch][lb_idx_s], m_s[ch]);
    end
  end

  // Counters, FSM, pairing/line-buffer storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      col_r        <= '0;
      row_r        <= '0;
      valid_out_r  <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        pair_r[ch] <= '0;
        pool_r[ch] <= '0;
        for (int i = 0; i < HALF_W; i++) begin
          line_buf_r[ch][i] <= '0;
        end
      end
    end else begin
      valid_out_r  <= 1'b0;
      frame_done_r <= 1'b0;
      if (valid_in) begin
        if (col_wrap_s) begin
          col_r <= '0;
          row_r <= row_last_s ? '0 : row_r + RW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end

        // Even col parks the sample; odd col either fills the line buffer
        // (even row) or completes the 2x2 window (odd row).
        for (int ch = 0; ch < 3; ch++) begin
          if (!col_odd_s) begin
            pair_r[ch] <= x_s[ch];
          end else if (!row_odd_s) begin
            line_buf_r[ch][lb_idx_s] <= m_s[ch];
          end else begin
            pool_r[ch] <= pool_s[ch];
          end
        end

        if (col_odd_s && row_odd_s) begin
          valid_out_r  <= 1'b1;
          frame_done_r <= col_wrap_s && row_last_s;
        end

        case (state_r)
          S_IDLE: begin
            state_r <= S_EVEN;
            busy_r  <= 1'b1;
          end
          S_EVEN: begin
            if (col_wrap_s) begin
              state_r <= S_ODD;
            end
          end
          S_ODD: begin
            if (col_wrap_s) begin
              if (row_last_s) begin
                state_r <= S_IDLE;
                busy_r  <= 1'b0;
              end else begin
                state_r <= S_EVEN;
              end
            end
          end
          default: begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pool_out_1 = pool_r[0];
  assign pool_out_2 = pool_r[1];
  assign pool_out_3 = pool_r[2];
  assign valid_out  = valid_out_r;
  assign frame_done = frame_done_r;
  assign busy       = busy_r;

endmodule
